// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with 16x oversampling and one-entry holding
//           register.
//
// The serial line is synchronized, a falling edge starts a frame, the start
// bit is re-checked at mid-bit, eight data bits are sampled LSB first at
// their centres and the stop bit is checked. Good bytes are placed in a
// holding register that the host consumes with rd_en.
//
// Parameters
//   CLK_FREQ    clock frequency in Hz
//   BAUD        line rate in bit/s
// Ports
//   clk_100m    in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   rx          in   asynchronous serial line, idle high
//   rd_en       in   consume the held byte (only acts while rx_ready=1)
//   data_out    out  last good byte received
//   rx_ready    out  data_out holds an unread byte
//   data_valid  out  one-cycle pulse when a good byte is loaded
//   frame_err   out  one-cycle pulse on a bad stop bit
//   overrun     out  one-cycle pulse when a good byte is dropped (rx_ready=1)
//   rx_busy     out  receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       rx_ready,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int SAMPLE_DIV = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Synchronizer and edge-detect registers
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic [2:0]       arm_q;

  // Receiver state
  state_t           state_q,    state_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [3:0]       samp_q,     samp_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [7:0]       shift_q,    shift_d;
  logic [7:0]       data_q,     data_d;
  logic             ready_q,    ready_d;
  logic             valid_q,    valid_d;
  logic             ferr_q,     ferr_d;
  logic             ovr_q,      ovr_d;
  logic             busy_q,     busy_d;

  logic             tick_s;
  logic             fall_s;

  // Two-flop synchronizer, one extra delayed copy for edge detection, and an
  // arming shift register that blocks edge detection until the pipeline holds
  // real line samples (reset values of 1 must not look like a high->low edge).
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= 3'b000;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      arm_q     <= {arm_q[1:0], 1'b1};
    end
  end

  assign tick_s = (div_q == DIV_LAST);
  assign fall_s = arm_q[2] & rx_prev_q & ~rx_s_q;

  // Next-state logic: divider, sample counter, bit sampling and the holding
  // register handshake.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    // Divider and sample counter only run while a frame is in progress;
    // the sample counter wraps 15->0 on its own.
    if (state_q != ST_IDLE) begin
      div_d = tick_s ? '0 : div_q + DIV_W'(1);
      if (tick_s) begin
        samp_d = samp_q + 4'd1;
      end else begin
        samp_d = samp_q;
      end
    end else begin
      div_d  = '0;
      samp_d = samp_q;
    end

    if (rd_en && ready_q) begin
      ready_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_START;
          div_d   = '0;
          samp_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Mid-start re-check rejects short low glitches.
      ST_START: begin
        if (tick_s && (samp_q == 4'd7)) begin
          samp_d    = 4'd0;
          bit_idx_d = 3'd0;
          if (!rx_s_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end

      // Data bits arrive LSB first, so shift in from the top.
      ST_DATA: begin
        if (tick_s && (samp_q == 4'd15)) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      // A read in the same cycle frees the holding register, so the new byte
      // is loaded rather than reported as an overrun.
      ST_STOP: begin
        if (tick_s && (samp_q == 4'd15)) begin
          state_d = ST_IDLE;
          if (rx_s_q) begin
            if (!ready_q || rd_en) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      samp_q    <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign rx_ready   = ready_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = busy_q;

endmodule
